// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix and debounces one key per press.
// Emits a one-cycle newkey strobe with keycode {1, row, col}.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       newkey,
  output logic [4:0] keycode
);
  localparam int CW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {SCAN, DEB, PRESSED} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] dcnt;
  logic [1:0] col_sel, lat_row, lat_col, pri;
  logic sample, any_low, hit, held_high, last;
  assign sample = cnt == CW'(SCAN_DIV - 1);
  assign any_low = ~&row;
  assign pri = ~row[0] ? 2'd0 : ~row[1] ? 2'd1 : ~row[2] ? 2'd2 : 2'd3;
  // during debounce the latched row must still be the priority winner
  assign hit = any_low && pri == lat_row;
  assign held_high = row[lat_row];
  assign last = dcnt + 4'd1 == 4'(DEBOUNCE);
  assign col = ~(4'b0001 << col_sel);
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state <= SCAN;
      cnt <= '0;
      dcnt <= '0;
      col_sel <= '0;
      lat_row <= '0;
      lat_col <= '0;
      newkey <= 1'b0;
      keycode <= '0;
    end else begin
      newkey <= 1'b0;
      cnt <= sample ? '0 : cnt + 1'b1;
      if (sample)
        case (state)
          SCAN:
            if (any_low) begin
              lat_row <= pri;
              lat_col <= col_sel;
              if (DEBOUNCE == 1) begin
                newkey <= 1'b1;
                keycode <= {1'b1, pri, col_sel};
                dcnt <= '0;
                state <= PRESSED;
              end else begin
                dcnt <= 4'd1;
                state <= DEB;
              end
            end else col_sel <= col_sel + 2'd1;
          DEB:
            if (!hit) begin
              dcnt <= '0;
              state <= SCAN;
              col_sel <= col_sel + 2'd1;
            end else if (last) begin
              newkey <= 1'b1;
              keycode <= {1'b1, lat_row, lat_col};
              dcnt <= '0;
              state <= PRESSED;
            end else dcnt <= dcnt + 4'd1;
          PRESSED:
            if (!held_high) dcnt <= '0;
            else if (last) begin
              dcnt <= '0;
              state <= SCAN;
              col_sel <= col_sel + 2'd1;
            end else dcnt <= dcnt + 4'd1;
          default: state <= SCAN;
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated key matrix and checks against a sample-level model.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DB = 3;
  logic clk5 = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row, col;
  logic [3:0] pull_low = 4'b0000;
  logic newkey;
  logic [4:0] keycode;
  logic [15:0] keys = '0;
  int vectors = 0, errors = 0;
  int m_win, m_col, m_mode, m_streak, m_row, m_lcol, m_key;
  logic m_newkey;
  int strobes, ticks;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DB)) dut (
    .clk5(clk5), .reset(reset), .row(row), .col(col), .newkey(newkey), .keycode(keycode)
  );

  always #5 clk5 = ~clk5;

  // a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = ~pull_low;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] model_row(input int c);
    logic [3:0] r;
    r = ~pull_low;
    for (int i = 0; i < 4; i++) if (keys[i*4+c]) r[i] = 1'b0;
    return r;
  endfunction

  function automatic void mreset();
    m_win = 0; m_col = 0; m_mode = 0; m_streak = 0; m_key = 0; m_newkey = 1'b0;
    m_row = 0; m_lcol = 0;
  endfunction

  function automatic void accept();
    m_newkey = 1'b1;
    m_key = 16 + m_row * 4 + m_lcol;
    m_mode = 2;
    m_streak = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] s, ecol;
    int low;
    s = model_row(m_col);
    @(posedge clk5); #1;
    if (!reset) mreset();
    else begin
      m_newkey = 1'b0;
      if (m_win == SCAN_DIV - 1) begin
        low = -1;
        for (int i = 3; i >= 0; i--) if (!s[i]) low = i;
        case (m_mode)
          0: if (low >= 0) begin
               m_row = low; m_lcol = m_col; m_streak = 1; m_mode = 1;
               if (m_streak >= DB) accept();
             end else m_col = (m_col + 1) % 4;
          1: if (low == m_row) begin
               m_streak++;
               if (m_streak >= DB) accept();
             end else begin
               m_mode = 0; m_col = (m_col + 1) % 4;
             end
          default: if (s[m_row]) begin
               m_streak++;
               if (m_streak >= DB) begin m_mode = 0; m_streak = 0; m_col = (m_col + 1) % 4; end
             end else m_streak = 0;
        endcase
      end
      m_win = (m_win + 1) % SCAN_DIV;
    end
    ticks++;
    if (newkey) strobes++;
    ecol = 4'b1111;
    ecol[m_col] = 1'b0;
    chk("col", col, ecol);
    chk("newkey", newkey, m_newkey);
    chk("keycode", keycode, m_key);
  endtask

  task automatic press(input int r, input int c, input int hold, input int gap, input logic [4:0] code);
    strobes = 0;
    keys = '0;
    keys[r*4+c] = 1'b1;
    repeat (hold) tick();
    chk("press_strobes", strobes, 1);
    chk("press_code", keycode, code);
    keys = '0;
    repeat (gap) tick();
  endtask

  initial begin
    mreset();
    strobes = 0;
    ticks = 0;
    repeat (2) @(posedge clk5);
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_newkey", newkey, 0);
    chk("rst_keycode", keycode, 0);
    @(negedge clk5) reset = 1'b1;
    repeat (4) tick();
    chk("idle_col1", col, 4'b1101);
    repeat (12) tick();
    chk("idle_wrap", col, 4'b1110);
    repeat (8) tick();

    press(0, 1, 40, 24, 5'b10001);
    press(0, 2, 40, 24, 5'b10010);
    press(2, 1, 40, 24, 5'b11001);
    press(1, 2, 40, 24, 5'b10110);

    // bounce: one low sample while scanning column 0
    for (int n = 0; n < 40 && !(m_mode == 0 && m_col == 0 && m_win == 0); n++) tick();
    chk("bounce_align", m_mode == 0 && m_col == 0 && m_win == 0, 1);
    strobes = 0;
    pull_low = 4'b0001;
    repeat (SCAN_DIV) tick();
    pull_low = 4'b0000;
    repeat (SCAN_DIV) tick();
    chk("bounce_col", col, 4'b1101);
    repeat (8) tick();
    chk("bounce_strobes", strobes, 0);

    // long hold, then a release glitch on the latched row
    strobes = 0;
    keys = '0; keys[3*4+3] = 1'b1;
    repeat (200) tick();
    chk("long_strobes", strobes, 1);
    chk("long_code", keycode, 5'b11111);
    keys = '0;
    for (int n = 0; n < 40 && !(m_mode == 2 && m_streak == 1 && m_win == 0); n++) tick();
    chk("glitch_align", m_mode == 2 && m_streak == 1 && m_win == 0, 1);
    pull_low = 4'b1000;
    repeat (SCAN_DIV) tick();
    pull_low = 4'b0000;
    repeat (2 * SCAN_DIV) tick();
    chk("glitch_held", col, 4'b0111);
    repeat (24) tick();
    press(3, 3, 60, 24, 5'b11111);

    // two rows on column 3: row 1 wins; a later key elsewhere is ignored
    strobes = 0;
    keys = '0; keys[2*4+3] = 1'b1; keys[1*4+3] = 1'b1;
    repeat (40) tick();
    chk("multi_code", keycode, 5'b10111);
    keys[0] = 1'b1;
    repeat (40) tick();
    chk("multi_strobes", strobes, 1);
    keys = '0;
    repeat (24) tick();

    // randomized presses, glitches and multi-key combinations
    repeat (25) begin
      keys = '0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(0, 60)) begin
        pull_low = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        tick();
      end
      pull_low = 4'b0000;
      keys = '0;
      repeat ($urandom_range(0, 30)) tick();
    end
    repeat (24) tick();

    // async reset during debounce after two low samples
    strobes = 0;
    keys = '0; keys[3*4+0] = 1'b1;
    for (int n = 0; n < 200 && !(m_mode == 1 && m_streak == 2); n++) tick();
    chk("deb2_reached", m_mode == 1 && m_streak == 2, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_col", col, 4'b1110);
    chk("async_newkey", newkey, 0);
    chk("async_keycode", keycode, 0);
    keys = '0;
    mreset();
    repeat (3) tick();
    @(negedge clk5) reset = 1'b1;
    repeat (20) tick();
    chk("async_strobes", strobes, 0);

    // latency from reset release with column-0 key already held
    @(negedge clk5) reset = 1'b0;
    tick();
    keys = '0; keys[0] = 1'b1;
    @(negedge clk5) reset = 1'b1;
    ticks = 0;
    for (int n = 0; n < 40 && !newkey; n++) tick();
    chk("latency", ticks, 12);
    chk("latency_code", keycode, 5'b10000);
    keys = '0;
    repeat (24) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low key matrix, debounces a single key press and emits a one-cycle newkey strobe with a 5-bit keycode. Sits directly upstream of combLockTop and drives its newkey/keycode inputs. Runs on clk5.

Parameters:
SCAN_DIV, 4, clk5 cycles each column is driven before the rows are sampled (min 2)
DEBOUNCE, 3, consecutive matching row samples required to accept a press or a release (min 1, max 15)

Ports:
clk5  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
row  in  4  matrix row inputs, active-low, externally pulled up; bit i = row i
col  out  4  matrix column drive, active-low, one-hot-low; bit j = column j
newkey  out  1  one-cycle strobe, key accepted
keycode  out  5  {1'b1, row_idx[1:0], col_idx[1:0]} of accepted key, held until next accept

Behaviour:
- Reset (reset=0, async): state=SCAN, col=4'b1110 (column 0), newkey=0, keycode=5'b00000, window counter=0, debounce counter=0, latched row/col=0.
- Column window: counter counts 0..SCAN_DIV-1; row is sampled when counter=SCAN_DIV-1. Cycle 0 is the first rising edge after reset deasserts.
- Row priority: if several row bits are low in a sample, the lowest index wins.
- SCAN: col rotates 0->1->2->3->0 at the end of each window (after the sample). Any row low at a sample -> latch row_idx/col_idx, debounce counter=1, go to DEBOUNCE; col does NOT advance.
- DEBOUNCE: col frozen. At each sample: if latched row is low (after priority) -> counter+1; else -> counter=0, go to SCAN, col advances to next column.
- Accept: when counter reaches DEBOUNCE (the DEBOUNCE-th consecutive low sample, including the first one), newkey=1 for exactly the next clock cycle, keycode updated in the same cycle, go to PRESSED. With DEBOUNCE=1, the detecting sample alone accepts.
- PRESSED: col frozen. Count consecutive samples in which the latched row is high. Any low sample clears the count. DEBOUNCE consecutive high samples -> go to SCAN, col advances. No auto-repeat; other keys are ignored while in PRESSED.
- newkey is never high on two consecutive cycles. keycode changes only in the newkey cycle. bit4 is always 1 after the first accept.
- A bounce (row high for one sample) during DEBOUNCE aborts the press, with no strobe.
- Reset mid-operation: immediate return to reset values; a pending press is discarded and newkey is forced low.
- Latency (defaults, key on column 0 held from reset release): samples at cycles 3, 7, 11; newkey=1 in cycle 12.

Test Plan:
- Reset: reset=0 with row=4'b1111 -> col=4'b1110, newkey=0, keycode=0. Release, no keys -> col steps 1110,1101,1011,0111 every 4 cycles, then wraps to 1110.
- Clean press row0/col1: row[0] low only while col=4'b1101, held 40 cycles -> exactly one newkey pulse, keycode=5'b10001. Sequence row0/col2, row2/col1, row1/col2 -> keycodes 10010, 11001, 10110, one strobe each.
- Bounce: row[0] low for 1 sample on column 0, then high -> no newkey; scanning resumes at column 1.
- Long hold: key held 200 cycles -> single newkey. Release with a 1-sample glitch low inside the release window -> still PRESSED; after 3 clean high samples, rescans; a second press gives a second strobe.
- Multi-key: row[2] and row[1] low together on column 3 -> keycode=5'b10111 (row1 wins). A key pressed on another column while PRESSED -> ignored.
- Async reset mid-DEBOUNCE (after 2 low samples) -> outputs return to reset values without waiting for a clock edge, and no newkey is produced.
